ahb_slave_arbiter: RTL and testbench
====================================

Name: ahb_slave_arbiter

Overview:
- Per-slave arbiter for the AHB interconnect. It generates the one-hot select vectors that drive a slave-side payload mux.
- It picks among masters whose decoders target this slave, using round-robin priority.
- Ownership is held for a whole AHB burst. Separate address-phase and data-phase selects are produced to follow the AHB pipeline.

Parameters:
- CHANNEL_NUM, 2, number of masters that can reach this slave (2..16).
- CNT_W, 5, burst beat counter width (holds up to 16).

Ports:
- HCLK  input  1  system clock.
- HRESETn  input  1  synchronous active-low reset.
- hreq  input  CHANNEL_NUM  per-master request (decoder hit for this slave).
- htrans  input  CHANNEL_NUM x 2  per-master HTRANS.
- hburst  input  CHANNEL_NUM x 3  per-master HBURST.
- hready  input  1  slave HREADYOUT (transfer accepted when 1).
- sel_addr  output  CHANNEL_NUM  one-hot address-phase select (all-zero = no owner).
- sel_data  output  CHANNEL_NUM  one-hot data/response-phase select.
- hmaster  output  $clog2(CHANNEL_NUM)  index of the address-phase owner.
- arb_locked  output  1  high while a burst is in progress (no re-arbitration).

Behaviour:
- Reset (HRESETn=0 at HCLK edge): sel_addr=0, sel_data=0, hmaster=0, arb_locked=0, beat_cnt=0, rr_ptr=0 (channel 0 highest priority), state=ARB_IDLE. Applies mid-burst; no transfer state is kept.
- All registers update only when hready=1, except reset. hready=0 freezes state, counter, pointer and both selects.
- sel_data <= sel_addr on each hready=1 edge, i.e. one accepted-transfer latency behind the address phase.
- Round-robin: the winner is the first requester, searched from index rr_ptr upward with wrap. On grant, rr_ptr <= winner+1 mod CHANNEL_NUM. No requester means sel_addr <= 0.
- States:
  - ARB_IDLE: no owner. Any hreq -> grant winner, go to ARB_OWN.
  - ARB_OWN: owner holds an address phase.
    - Owner htrans=NONSEQ with hburst in {INCR4,WRAP4,INCR8,WRAP8,INCR16,WRAP16}: load beat_cnt = len-1 (3/7/15), go to ARB_BURST, arb_locked=1.
    - Owner htrans=NONSEQ with hburst=INCR: go to ARB_INCR, arb_locked=1.
    - Otherwise (SINGLE or IDLE): re-arbitrate on this edge; no requesters -> ARB_IDLE.
  - ARB_BURST:
    - SEQ accepted: beat_cnt decrements.
    - BUSY: beat_cnt holds.
    - SEQ accepted with beat_cnt==1: last beat; re-arbitrate next edge (ARB_OWN), arb_locked=0.
    - Owner htrans=IDLE or NONSEQ (early termination): treated as burst end; re-arbitrate immediately.
  - ARB_INCR: hold while owner htrans is SEQ or BUSY. Owner IDLE/NONSEQ or hreq[owner]=0 -> re-arbitrate.
- Grant never moves while arb_locked=1, even if higher-priority requests arrive.
- Owner keeps requesting in ARB_OWN: it is still subject to round-robin, so other requesters get a turn after each SINGLE.
- sel_addr and sel_data are always one-hot or zero. hmaster=0 when sel_addr=0.

Decomposition:
- AHB_package holds:
  - htrans_t enum (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
  - hburst_t enum (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
  - arb_state_t enum (ARB_IDLE, ARB_OWN, ARB_BURST, ARB_INCR).
  - burst_len function (hburst_t -> beats).
- One sub-module, ahb_rr_picker: combinational round-robin picker. Inputs req and ptr; outputs one-hot grant and index.

Test Plan:
- Reset mid-burst: CHANNEL_NUM=2, master0 in INCR8 at beat 3, HRESETn=0 for 1 cycle -> next cycle sel_addr=00, sel_data=00, arb_locked=0; first grant after reset goes to master0.
- Round-robin: hreq=11, both issue SINGLE NONSEQ, hready=1 -> sel_addr alternates 01,10,01,10; sel_data lags sel_addr by one cycle.
- Fixed burst hold: master1 INCR4 (NONSEQ+3 SEQ) while master0 requests -> sel_addr=10 for exactly 4 accepted beats, then 01; arb_locked high for beats 1-3.
- Wait states and BUSY: master0 WRAP4 with hready=0 for 2 cycles on beat 2 and one BUSY -> beat_cnt and selects frozen during stalls; grant released only after the 4th SEQ-or-NONSEQ accepted.
- Undefined INCR and early end: master1 INCR of 6 SEQ, then htrans=IDLE -> grant held 7 beats, moves to master0 on the next edge. Separately, master0 INCR8 terminated by IDLE at beat 5 -> re-arbitration on that edge.
- Idle: hreq=00 -> sel_addr=00, state ARB_IDLE. hreq=10 on the next cycle -> sel_addr=10 one edge later, hmaster=1.

Source files
------------

// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB encodings and arbiter state for the per-slave arbiter.
package ahb_slave_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_BURST = 2'd2,
    ARB_INCR  = 2'd3
  } arb_state_t;

  localparam int BEAT_W = 5;

  // Number of beats of a burst type; INCR has no fixed length and reports 0.
  function automatic logic [BEAT_W-1:0] burst_len(input hburst_t hb);
    case (hb)
      SINGLE:          burst_len = 5'd1;
      WRAP4, INCR4:    burst_len = 5'd4;
      WRAP8, INCR8:    burst_len = 5'd8;
      WRAP16, INCR16:  burst_len = 5'd16;
      default:         burst_len = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slave_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or above ptr, with wrap.
module ahb_rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] cand_s;

  // Walk the request vector starting at ptr and latch the first hit.
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    sum_s  = '0;
    cand_s = '0;
    for (int i = 0; i < N; i++) begin
      sum_s = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum_s >= (IDX_W+1)'(N)) begin
        sum_s = sum_s - (IDX_W+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IDX_W-1:0];
      if (!any && req[cand_s]) begin
        any          = 1'b1;
        idx          = cand_s;
        grant[cand_s] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: round-robin grant held across bursts, with
// address-phase and data-phase one-hot selects for the slave payload mux.
module ahb_slave_arbiter
  import ahb_slave_arbiter_pkg::*;
#(
  parameter  int CHANNEL_NUM = 2,
  parameter  int CNT_W       = 5,
  localparam int IDX_W       = $clog2(CHANNEL_NUM)
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic [CHANNEL_NUM-1:0]      hreq,
  input  logic [CHANNEL_NUM-1:0][1:0] htrans,
  input  logic [CHANNEL_NUM-1:0][2:0] hburst,
  input  logic                        hready,
  output logic [CHANNEL_NUM-1:0]      sel_addr,
  output logic [CHANNEL_NUM-1:0]      sel_data,
  output logic [IDX_W-1:0]            hmaster,
  output logic                        arb_locked
);

  arb_state_t             state_r, state_nxt_s;
  logic [CHANNEL_NUM-1:0] sel_addr_r, sel_addr_nxt_s, sel_data_r;
  logic [IDX_W-1:0]       hmaster_r, hmaster_nxt_s;
  logic [IDX_W-1:0]       rr_ptr_r, rr_ptr_nxt_s;
  logic [CNT_W-1:0]       beat_cnt_r, beat_cnt_nxt_s;
  logic                   arb_locked_r;
  logic                   rearb_s;

  logic [CHANNEL_NUM-1:0] pick_grant_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic                   pick_any_s;

  htrans_t                own_trans_s;
  hburst_t                own_burst_s;
  logic                   own_req_s;
  logic [BEAT_W-1:0]      own_len_s;

  ahb_rr_picker #(.N(CHANNEL_NUM), .IDX_W(IDX_W)) u_picker (
    .req   (hreq),
    .ptr   (rr_ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  assign own_trans_s = htrans_t'(htrans[hmaster_r]);
  assign own_burst_s = hburst_t'(hburst[hmaster_r]);
  assign own_req_s   = hreq[hmaster_r];
  assign own_len_s   = burst_len(own_burst_s);

  // Next state, grant and beat count for the current owner's address phase.
  always_comb begin
    state_nxt_s    = state_r;
    sel_addr_nxt_s = sel_addr_r;
    hmaster_nxt_s  = hmaster_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    beat_cnt_nxt_s = beat_cnt_r;
    rearb_s        = 1'b0;

    case (state_r)
      ARB_IDLE: begin
        rearb_s = 1'b1;
      end
      ARB_OWN: begin
        if ((own_trans_s == NONSEQ) && (own_len_s >= 5'd4)) begin
          beat_cnt_nxt_s = CNT_W'(own_len_s - 5'd1);
          state_nxt_s    = ARB_BURST;
        end else if ((own_trans_s == NONSEQ) && (own_burst_s == INCR)) begin
          state_nxt_s = ARB_INCR;
        end else begin
          rearb_s = 1'b1;
        end
      end
      ARB_BURST: begin
        case (own_trans_s)
          SEQ: begin
            // A count of 0 here cannot occur in a legal burst; release anyway.
            if (beat_cnt_r <= CNT_W'(1)) begin
              rearb_s = 1'b1;
            end else begin
              beat_cnt_nxt_s = beat_cnt_r - CNT_W'(1);
            end
          end
          BUSY:    beat_cnt_nxt_s = beat_cnt_r;
          default: rearb_s = 1'b1;
        endcase
      end
      ARB_INCR: begin
        if (((own_trans_s == SEQ) || (own_trans_s == BUSY)) && own_req_s) begin
          state_nxt_s = ARB_INCR;
        end else begin
          rearb_s = 1'b1;
        end
      end
      default: begin
        rearb_s = 1'b1;
      end
    endcase

    if (rearb_s) begin
      beat_cnt_nxt_s = '0;
      if (pick_any_s) begin
        sel_addr_nxt_s = pick_grant_s;
        hmaster_nxt_s  = pick_idx_s;
        rr_ptr_nxt_s   = (pick_idx_s == IDX_W'(CHANNEL_NUM-1)) ? '0
                                                               : pick_idx_s + IDX_W'(1);
        state_nxt_s    = ARB_OWN;
      end else begin
        sel_addr_nxt_s = '0;
        hmaster_nxt_s  = '0;
        state_nxt_s    = ARB_IDLE;
      end
    end else begin
      sel_addr_nxt_s = sel_addr_r;
    end
  end

  // Arbiter registers; everything freezes while the slave inserts wait states.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_r      <= ARB_IDLE;
      sel_addr_r   <= '0;
      sel_data_r   <= '0;
      hmaster_r    <= '0;
      rr_ptr_r     <= '0;
      beat_cnt_r   <= '0;
      arb_locked_r <= 1'b0;
    end else if (hready) begin
      state_r      <= state_nxt_s;
      sel_addr_r   <= sel_addr_nxt_s;
      sel_data_r   <= sel_addr_r;
      hmaster_r    <= hmaster_nxt_s;
      rr_ptr_r     <= rr_ptr_nxt_s;
      beat_cnt_r   <= beat_cnt_nxt_s;
      arb_locked_r <= (state_nxt_s == ARB_BURST) || (state_nxt_s == ARB_INCR);
    end
  end

  assign sel_addr   = sel_addr_r;
  assign sel_data   = sel_data_r;
  assign hmaster    = hmaster_r;
  assign arb_locked = arb_locked_r;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed, table-driven bench for the two-master configuration of ahb_slave_arbiter.
module tb_ahb_slave_arbiter;

  localparam logic [1:0] T_I  = 2'd0;
  localparam logic [1:0] T_B  = 2'd1;
  localparam logic [1:0] T_NS = 2'd2;
  localparam logic [1:0] T_S  = 2'd3;
  localparam logic [2:0] B_SG = 3'd0;
  localparam logic [2:0] B_IN = 3'd1;
  localparam logic [2:0] B_W4 = 3'd2;
  localparam logic [2:0] B_I4 = 3'd3;
  localparam logic [2:0] B_I8 = 3'd5;
  localparam logic [2:0] B_16 = 3'd7;

  logic            HCLK;
  logic            HRESETn;
  logic [1:0]      hreq;
  logic [1:0][1:0] htrans;
  logic [1:0][2:0] hburst;
  logic            hready;
  logic [1:0]      sel_addr;
  logic [1:0]      sel_data;
  logic [0:0]      hmaster;
  logic            arb_locked;

  int n_cmp;
  int n_err;

  ahb_slave_arbiter #(.CHANNEL_NUM(2), .CNT_W(5)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .hreq       (hreq),
    .htrans     (htrans),
    .hburst     (hburst),
    .hready     (hready),
    .sel_addr   (sel_addr),
    .sel_data   (sel_data),
    .hmaster    (hmaster),
    .arb_locked (arb_locked)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [1:0] hq;
    logic [1:0] t0;
    logic [1:0] t1;
    logic [2:0] b0;
    logic [2:0] b1;
    logic       rdy;
    logic       rstn;
    logic [1:0] sa;
    logic [1:0] sd;
    logic       hm;
    logic       lk;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] hq, input logic [1:0] t0, input logic [1:0] t1,
                     input logic [2:0] b0, input logic [2:0] b1, input logic rdy,
                     input logic rstn, input logic [1:0] sa, input logic [1:0] sd,
                     input logic hm, input logic lk);
    vec_t v;
    v.hq = hq; v.t0 = t0; v.t1 = t1; v.b0 = b0; v.b1 = b1; v.rdy = rdy; v.rstn = rstn;
    v.sa = sa; v.sd = sd; v.hm = hm; v.lk = lk;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, id, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] hq, input logic [1:0] t0, input logic [1:0] t1,
                       input logic [2:0] b0, input logic [2:0] b1, input logic rdy,
                       input logic rstn);
    hreq    = hq;
    htrans  = {t1, t0};
    hburst  = {b1, b0};
    hready  = rdy;
    HRESETn = rstn;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_all(input int id, input logic [1:0] sa, input logic [1:0] sd,
                         input logic hm, input logic lk);
    chk("sel_addr", id, 8'(sel_addr), 8'(sa));
    chk("sel_data", id, 8'(sel_data), 8'(sd));
    chk("hmaster", id, 8'(hmaster), 8'(hm));
    chk("arb_locked", id, 8'(arb_locked), 8'(lk));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // reset
    add(2'b00, T_I,  T_I,  B_SG, B_SG, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    add(2'b00, T_I,  T_I,  B_SG, B_SG, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    // round-robin of SINGLEs
    add(2'b11, T_NS, T_NS, B_SG, B_SG, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
    add(2'b11, T_NS, T_NS, B_SG, B_SG, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 1'b0);
    add(2'b11, T_NS, T_NS, B_SG, B_SG, 1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0);
    add(2'b11, T_NS, T_NS, B_SG, B_SG, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 1'b0);
    // master1 INCR4 with master0 requesting
    add(2'b11, T_NS, T_NS, B_SG, B_I4, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1);
    add(2'b11, T_NS, T_S,  B_SG, B_I4, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1);
    add(2'b11, T_NS, T_S,  B_SG, B_I4, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1);
    add(2'b11, T_NS, T_S,  B_SG, B_I4, 1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0);
    // master0 WRAP4 with stalls and BUSY
    add(2'b11, T_NS, T_I,  B_W4, B_SG, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0);
    add(2'b11, T_NS, T_I,  B_W4, B_SG, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1);
    add(2'b11, T_S,  T_I,  B_W4, B_SG, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1);
    add(2'b11, T_S,  T_I,  B_W4, B_SG, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1);
    add(2'b11, T_S,  T_I,  B_W4, B_SG, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1);
    add(2'b11, T_B,  T_I,  B_W4, B_SG, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1);
    add(2'b11, T_S,  T_I,  B_W4, B_SG, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1);
    add(2'b11, T_S,  T_I,  B_W4, B_SG, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 1'b0);
    // master1 undefined INCR: NONSEQ + 6 SEQ, then IDLE
    add(2'b11, T_I,  T_NS, B_SG, B_IN, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      add(2'b11, T_I, T_S, B_SG, B_IN, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1);
    end
    add(2'b11, T_I,  T_I,  B_SG, B_IN, 1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0);
    // master0 INCR8 cut short by IDLE on beat 5
    add(2'b11, T_NS, T_I,  B_I8, B_SG, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      add(2'b11, T_S, T_I, B_I8, B_SG, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1);
    end
    add(2'b11, T_I,  T_I,  B_I8, B_SG, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 1'b0);
    // reset in the middle of a master0 INCR8
    add(2'b11, T_I,  T_I,  B_SG, B_SG, 1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0);
    add(2'b11, T_NS, T_I,  B_I8, B_SG, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1);
    add(2'b11, T_S,  T_I,  B_I8, B_SG, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1);
    add(2'b11, T_S,  T_I,  B_I8, B_SG, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1);
    add(2'b11, T_S,  T_I,  B_I8, B_SG, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    add(2'b11, T_NS, T_I,  B_SG, B_SG, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
    // idle, then a lone master1 request
    add(2'b00, T_I,  T_I,  B_SG, B_SG, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0);
    add(2'b10, T_I,  T_I,  B_SG, B_SG, 1'b1, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0);
    // INCR with BUSY, ended by the owner dropping its request
    add(2'b10, T_I,  T_NS, B_SG, B_IN, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1);
    add(2'b10, T_I,  T_B,  B_SG, B_IN, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1);
    add(2'b00, T_I,  T_S,  B_SG, B_IN, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0);
    add(2'b00, T_I,  T_I,  B_SG, B_SG, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].hq, tbl[i].t0, tbl[i].t1, tbl[i].b0, tbl[i].b1, tbl[i].rdy, tbl[i].rstn);
      step();
      chk_all(i, tbl[i].sa, tbl[i].sd, tbl[i].hm, tbl[i].lk);
    end

    // INCR16 from master0 with a wait state before every SEQ; master1 waits.
    drive(2'b11, T_NS, T_NS, B_16, B_SG, 1'b1, 1'b1);
    step();
    chk_all(100, 2'b01, 2'b00, 1'b0, 1'b0);
    step();
    chk_all(101, 2'b01, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      drive(2'b11, T_S, T_NS, B_16, B_SG, 1'b0, 1'b1);
      step();
      chk_all(200 + 2 * i, 2'b01, 2'b01, 1'b0, 1'b1);
      hready = 1'b1;
      step();
      if (i < 14) begin
        chk_all(201 + 2 * i, 2'b01, 2'b01, 1'b0, 1'b1);
      end else begin
        chk_all(201 + 2 * i, 2'b10, 2'b01, 1'b1, 1'b0);
      end
    end
    drive(2'b10, T_I, T_NS, B_SG, B_SG, 1'b1, 1'b1);
    step();
    chk_all(300, 2'b10, 2'b10, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
